// File: rtl/mux_scan_if.sv
// mux_scan_if: source/consumer-side signal bundle for mux_scan; MUX_SCAN_MASK_EN adds chan_mask.
// Latency: none, wiring only.
// Backpressure: out_valid/out_ready handshake on the sample side; start is a single-cycle request.
interface mux_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [SELW-1:0]           sel;
  logic                      mode;
  logic                      start;
  logic                      out_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      busy;
`ifdef MUX_SCAN_MASK_EN
  logic [CHANNELS-1:0]       chan_mask;

  modport master (
    output in_data, sel, mode, start, out_ready, chan_mask,
    input  out_valid, out_data, out_chan, busy
  );
  modport slave (
    input  in_data, sel, mode, start, out_ready, chan_mask,
    output out_valid, out_data, out_chan, busy
  );
`else
  modport master (
    output in_data, sel, mode, start, out_ready,
    input  out_valid, out_data, out_chan, busy
  );
  modport slave (
    input  in_data, sel, mode, start, out_ready,
    output out_valid, out_data, out_chan, busy
  );
`endif
endinterface

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel mux, manual select or ascending scan; MUX_SCAN_MASK_EN adds a scan channel mask.
// Latency: start -> first sample valid one cycle later; scan then delivers one sample per cycle.
// Backpressure: out_ready low freezes all outputs; start is ignored (not queued) while busy.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic              mode_q;
  logic              valid_q;
  logic [WIDTH-1:0]  data_q;
  logic [SELW-1:0]   chan_q;

  logic              start_ok;
  logic              nxt_found;
  logic [SELW-1:0]   first_chan;
  logic [SELW-1:0]   nxt_chan;
  logic [SELW-1:0]   cap_chan;
  logic [WIDTH-1:0]  cap_data;

`ifdef MUX_SCAN_MASK_EN
  logic [CHANNELS-1:0] mask_q;

  // Descending walk so the lowest qualifying index wins.
  always_comb begin
    first_chan = '0;
    nxt_chan   = '0;
    nxt_found  = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (bus.chan_mask[i]) first_chan = SELW'(i);
      if (mask_q[i] && (i > int'(chan_q))) begin
        nxt_chan  = SELW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  assign start_ok = !bus.mode || (|bus.chan_mask);
`else
  assign first_chan = '0;
  assign nxt_found  = (chan_q != SELW'(CHANNELS - 1));
  assign nxt_chan   = chan_q + SELW'(1);
  assign start_ok   = 1'b1;
`endif

  // Out-of-range indices fall through every compare and yield zero data.
  always_comb begin
    cap_chan = (state == IDLE) ? (bus.mode ? first_chan : bus.sel) : nxt_chan;
    cap_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(cap_chan) == i) cap_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
`ifdef MUX_SCAN_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && start_ok) begin
            mode_q  <= bus.mode;
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= bus.chan_mask;
`endif
            valid_q <= 1'b1;
            data_q  <= cap_data;
            chan_q  <= cap_chan;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            // Scan continues without a bubble; otherwise this acceptance ends the request.
            if (mode_q && nxt_found) begin
              data_q <= cap_data;
              chan_q <= cap_chan;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel W-bit multiplexer, successor to the lab 2:1 gate-level mux (z = a·¬c + b·c). Selects one channel on request (manual mode) or walks every channel in order (scan mode), presenting each captured sample on a registered output with a valid/ready handshake. Sits between parallel data sources and a single serial consumer.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2; need not be a power of two)
- SELW, derived = $clog2(CHANNELS), select/channel-index width (localparam, not overridable)

- clk  in  1  rising-edge clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- sel  in  SELW  channel index for manual mode, sampled on accepted start
- mode  in  1  0 = manual, 1 = scan; sampled on accepted start
- start  in  1  single-cycle request; honoured only in IDLE
- out_ready  in  1  consumer accepts current sample
- out_valid  out  1  out_data/out_chan hold a sample
- out_data  out  WIDTH  captured sample
- out_chan  out  SELW  channel index of out_data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, HOLD. busy = (state != IDLE).
- IDLE + start=1: latch mode, capture channel, out_valid←1, go HOLD. Manual: channel = sel. Scan: channel = 0 (first enabled channel when mask feature compiled in).
- sel ≥ CHANNELS in manual mode: out_data←0, out_chan←sel, handshake proceeds normally.
- HOLD, out_ready=0: all outputs frozen.
- HOLD, out_ready=1, manual: out_valid←0, go IDLE.
- HOLD, out_ready=1, scan, not last channel: capture next channel same edge (out_valid stays 1, no bubble), out_chan increments.
- HOLD, out_ready=1, scan, last channel (CHANNELS-1, or last enabled): out_valid←0, go IDLE.
- Channel counter never exceeds CHANNELS-1; no wrap to index 0 within one scan.
- start while busy: ignored, no queueing.
- in_data sampled only at capture edges; changes between captures never affect out_data.

## Timing
- Reset (async, any state, mid-scan included): state=IDLE, out_valid=0, out_data=0, out_chan=0, busy=0; in-progress scan discarded.
- start at edge k → out_valid=1 and busy=1 visible after edge k (1-cycle latency).
- Scan throughput: one sample per cycle with out_ready held high; full scan = CHANNELS cycles of out_valid.
- IDLE → start accepted on the edge immediately after the final acceptance (back-to-back: busy low for ≥1 cycle sampled by start).
- out_valid never deasserts without an acceptance; out_data/out_chan stable while out_valid=1 and out_ready=0.

## Configuration
- MUX_SCAN_MASK_EN defined: adds input chan_mask [CHANNELS]; sampled into a register on accepted start; scan mode visits only channels with mask bit 1, ascending; all-zero mask → start ignored (stays IDLE). Manual mode ignores mask.
- Undefined: no chan_mask port; scan visits every channel 0..CHANNELS-1.

## Test plan
- Reset: rst_n=0 mid-scan (out_chan=2, CHANNELS=4) → out_valid=0, out_data=0, out_chan=0, busy=0 immediately, without a clock edge.
- Manual: WIDTH=8, in_data={8'hDD,8'hCC,8'hBB,8'hAA}, sel=2, start → next cycle out_data=8'hCC, out_chan=2; out_ready=1 → out_valid=0, busy=0.
- Scan, out_ready=1: same data → out_data AA,BB,CC,DD on four consecutive cycles, out_chan 0..3, then out_valid=0.
- Backpressure: scan with out_ready=0 for 3 cycles at channel 1 → out_data=8'hBB held; start pulses during scan ignored; CHANNELS=3 scan stops after out_chan=2.
- Manual sel=5 with CHANNELS=5 (out of range) → out_data=0, out_chan=5, completes on out_ready.
- With MUX_SCAN_MASK_EN, chan_mask=4'b1010 → samples only from channels 1 and 3; chan_mask=0 → start ignored, busy stays 0.
